// File: rtl/ram_loader_pkg.sv
// Shared types and sizing helpers for the RAM block loader.
package ram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH,
    DONE
  } state_t;

  function automatic int num_words(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int lane_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_loader_lane_packer.sv
// Shadow lane register with per-word widening into PE lanes.
// Define RAM_LOADER_SIGN_EXT_EN to sign-extend words (default zero-extend).
module ram_loader_lane_packer
  import ram_loader_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4,
  parameter int LANE_W         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [RAM_DATA_WIDTH-1:0]      word,
  input  logic [LANE_W-1:0]              lane,
  input  logic                           wr,
  input  logic                           commit,
  output logic [PE_DATA_WIDTH*DEPTH-1:0] data_out
);

  logic [DEPTH-1:0][PE_DATA_WIDTH-1:0] shadow;
  logic [DEPTH-1:0][PE_DATA_WIDTH-1:0] next_shadow;
  logic [PE_DATA_WIDTH-1:0]            ext;

`ifdef RAM_LOADER_SIGN_EXT_EN
  assign ext = PE_DATA_WIDTH'($signed(word));
`else
  assign ext = PE_DATA_WIDTH'(word);
`endif

  // Commit sees the word captured this cycle, so the block is whole.
  always_comb begin
    next_shadow = shadow;
    if (wr) next_shadow[lane] = ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow   <= '0;
      data_out <= '0;
    end else begin
      shadow <= next_shadow;
      if (commit) data_out <= next_shadow;
    end
  end

endmodule

// File: rtl/ram_block_loader.sv
// Streams a whole async-read RAM into DEPTH-wide PE blocks.
// RAM_LOADER_SIGN_EXT_EN selects sign- instead of zero-extension.
module ram_block_loader
  import ram_loader_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [PE_DATA_WIDTH*DEPTH-1:0] data_out,
  output logic                           data_valid,
  output logic [RAM_ADDR_WIDTH-1:0]      ram_address,
  input  logic [RAM_DATA_WIDTH-1:0]      ram_data,
  output logic                           done
);

  localparam int LW = lane_w(DEPTH);
  localparam int N  = num_words(RAM_ADDR_WIDTH);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_BASE =
    RAM_ADDR_WIDTH'(N - DEPTH);

  state_t                    state;
  logic [LW-1:0]             word_counter;
  logic [RAM_ADDR_WIDTH-1:0] base_addr;
  logic                      capture;
  logic                      commit;
  logic                      last;

  assign capture = (state == LOAD);
  assign commit  = capture && (word_counter == LW'(DEPTH - 1));
  assign last    = commit && (base_addr == LAST_BASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ram_address  <= '0;
      word_counter <= '0;
      base_addr    <= '0;
      data_valid   <= 1'b0;
      done         <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          data_valid  <= 1'b0;
          ram_address <= '0;
          if (start) begin
            state        <= LOAD;
            word_counter <= '0;
            base_addr    <= '0;
            done         <= 1'b0;
          end
        end
        LOAD: begin
          ram_address  <= ram_address + 1'b1;
          word_counter <= word_counter + 1'b1;
          data_valid   <= commit;
          if (commit) base_addr <= base_addr + RAM_ADDR_WIDTH'(DEPTH);
          if (last) state <= FINISH;
        end
        FINISH: begin
          data_valid <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_loader_lane_packer #(
    .RAM_DATA_WIDTH(RAM_DATA_WIDTH),
    .PE_DATA_WIDTH (PE_DATA_WIDTH),
    .DEPTH         (DEPTH),
    .LANE_W        (LW)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .word    (ram_data),
    .lane    (word_counter),
    .wr      (capture),
    .commit  (commit),
    .data_out(data_out)
  );

endmodule

// File: tb/tb_ram_block_loader.sv
// Scoreboard bench for ram_block_loader with a RAM model.
// Honours RAM_LOADER_SIGN_EXT_EN for expected lane values.
module tb_ram_block_loader;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int PW  = 16;
  localparam int D   = 4;
  localparam int N   = 1 << AW;
  localparam int NB  = N / D;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [PW*D-1:0] data_out;
  logic          data_valid;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          done;

  logic [DW-1:0] mem [N];
  assign ram_data = mem[ram_address];

  ram_block_loader #(
    .RAM_ADDR_WIDTH(AW),
    .RAM_DATA_WIDTH(DW),
    .PE_DATA_WIDTH (PW),
    .DEPTH         (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int last_cyc = 0;
  logic [PW*D-1:0] exp_q [$];
  logic [PW*D-1:0] seen [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] ext(input logic [DW-1:0] v);
`ifdef RAM_LOADER_SIGN_EXT_EN
    if (v >= 8'd128) return 16'hFF00 + 16'(v);
`endif
    return 16'(v);
  endfunction

  // Monitor: pop one expected block per data_valid pulse.
  always @(negedge clk) begin
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(data_out), 64'h0);
        if (data_out == 64'h0) check("unexpected_valid", 1, 0);
      end else begin
        check("block", 64'(data_out), 64'(exp_q.pop_front()));
      end
      if (pulses > 0) check("pulse_spacing", 64'(cyc - last_cyc), 64'(D));
      last_cyc = cyc;
      pulses++;
      seen.push_back(data_out);
      if (done) check("valid_in_done", 1, 0);
    end
  end

  task automatic push_expected();
    logic [PW*D-1:0] blk;
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      blk = '0;
      for (int i = 0; i < D; i++)
        blk |= (PW*D)'(ext(mem[b*D+i])) << (PW*i);
      exp_q.push_back(blk);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_data_out"}, 64'(data_out), 64'h0);
    check({name, "_valid"}, 64'(data_valid), 64'h0);
    check({name, "_done"}, 64'(done), 64'h0);
    check({name, "_addr"}, 64'(ram_address), 64'h0);
  endtask

  // mid: edge index for a stray start; rst_at: edge index for reset.
  task automatic run_load(input int mid, input int rst_at,
                          input bit chk_first, input logic [63:0] first,
                          input bit chk_last, input logic [63:0] lastb);
    int done_k;
    push_expected();
    seen.delete();
    pulses = 0;
    done_k = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("done_drop", 64'(done), 64'h0);
    for (int k = 1; k <= 100 && done_k == 0; k++) begin
      start = (k == mid);
      reset = (k == rst_at);
      @(negedge clk);
      if (k == rst_at) begin
        reset = 1'b0;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        return;
      end
      if (done) done_k = k;
    end
    start = 1'b0;
    check("done_edge", 64'(done_k), 64'(N + 1));
    check("pulse_count", 64'(pulses), 64'(NB));
    check("addr_in_done", 64'(ram_address), 64'h0);
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    if (chk_first && seen.size() > 0)
      check("first_block", 64'(seen[0]), first);
    if (chk_last && seen.size() == NB)
      check("last_block", 64'(seen[NB-1]), lastb);
    repeat (3) @(negedge clk);
    check("done_held", 64'(done), 64'h1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = DW'(i + 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    run_load(0, 0, 1, 64'h0004_0003_0002_0001,
             1, 64'h0040_003f_003e_003d);
    run_load(10, 0, 1, 64'h0004_0003_0002_0001,
             1, 64'h0040_003f_003e_003d);
    run_load(0, 30, 0, 64'h0, 0, 64'h0);
    @(negedge clk);
    check_idle_outputs("after_reset");
    run_load(0, 0, 1, 64'h0004_0003_0002_0001,
             1, 64'h0040_003f_003e_003d);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
      run_load(0, 0, 0, 64'h0, 0, 64'h0);
    end

    mem[0] = 8'h80;
    mem[1] = 8'hFF;
    mem[2] = 8'h01;
    mem[3] = 8'h7F;
`ifdef RAM_LOADER_SIGN_EXT_EN
    run_load(0, 0, 1, 64'h007f_0001_ffff_ff80, 0, 64'h0);
`else
    run_load(0, 0, 1, 64'h007f_0001_00ff_0080, 0, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
